// File: rtl/axi_mem_responder_pkg.sv
// Shared types, response codes and burst address arithmetic for the AXI memory responder.
package axi_mem_responder_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_cmd_t;

  // Address of the following beat; reserved burst type 2'b11 behaves as INCR.
  function automatic logic [AXI_ADDR_W-1:0] next_addr(input logic [AXI_ADDR_W-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [AXI_ADDR_W-1:0] step;
    logic [AXI_ADDR_W-1:0] mask;
    step = AXI_ADDR_W'(1) << size;
    mask = ((AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size) - AXI_ADDR_W'(1);
    case (burst_t'(burst))
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:     next_addr = addr + step;
    endcase
  endfunction

endpackage

// File: rtl/axi_rdy_lfsr.sv
// Ready-gate generator: always open, or open when a free-running Galois LFSR clears a threshold.
module axi_rdy_lfsr
  import axi_mem_responder_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       mode,
  input  logic [3:0] thresh,
  output logic       gate
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  // Gate is registered alongside the LFSR so mode/threshold changes land on the next cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr <= LFSR_SEED;
      gate <= 1'b0;
    end else begin
      lfsr <= lfsr_d;
      gate <= !mode || (lfsr_d[3:0] >= thresh);
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a word memory, with independent read/write FSMs and a shared ready gate.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 1,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                rdy_mode,
  input  logic [3:0]          rdy_thresh,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              gate;
  logic [DATA_W-1:0] mem [DEPTH];

  axi_rdy_lfsr #(.LFSR_SEED(LFSR_SEED)) u_rdy_lfsr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .mode    (rdy_mode),
    .thresh  (rdy_thresh),
    .gate    (gate)
  );

  // ---------------- write path ----------------
  w_state_t        w_state, w_state_d;
  ax_cmd_t         aw_cmd, aw_cmd_d;
  logic [ID_W-1:0] aw_id, aw_id_d, bid_d;
  logic            w_err, w_err_d, bvalid_d, w_beat_err, w_we;
  logic [1:0]      bresp_d;

  assign s_awready  = gate && (w_state == W_IDLE);
  assign s_wready   = gate && (w_state == W_DATA);
  assign w_beat_err = aw_cmd.addr[ADDR_W-1:2] >= IDX_W'(DEPTH);

  always_comb begin
    w_state_d = w_state;
    aw_cmd_d  = aw_cmd;
    aw_id_d   = aw_id;
    w_err_d   = w_err;
    bvalid_d  = s_bvalid;
    bid_d     = s_bid;
    bresp_d   = s_bresp;
    w_we      = 1'b0;
    case (w_state)
      W_IDLE: if (s_awvalid && s_awready) begin
        aw_cmd_d  = '{addr: AXI_ADDR_W'(s_awaddr), len: s_awlen, size: s_awsize, burst: s_awburst};
        aw_id_d   = s_awid;
        w_err_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (s_wvalid && s_wready) begin
        w_we          = !w_beat_err;
        w_err_d       = w_err || w_beat_err;
        aw_cmd_d.addr = next_addr(aw_cmd.addr, aw_cmd.size, aw_cmd.len, aw_cmd.burst);
        if (s_wlast) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bid_d     = aw_id;
          bresp_d   = (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (s_bready) begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      aw_cmd   <= '0;
      aw_id    <= '0;
      w_err    <= 1'b0;
      s_bvalid <= 1'b0;
      s_bid    <= '0;
      s_bresp  <= RESP_OKAY;
    end else begin
      w_state  <= w_state_d;
      aw_cmd   <= aw_cmd_d;
      aw_id    <= aw_id_d;
      w_err    <= w_err_d;
      s_bvalid <= bvalid_d;
      s_bid    <= bid_d;
      s_bresp  <= bresp_d;
    end
  end

  // Contents survive reset; a same-edge read of this word still sees the old value.
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_wstrb[b]) mem[aw_cmd.addr[MEM_AW+1:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state, r_state_d;
  ax_cmd_t               ar_cmd, ar_cmd_d;
  logic [7:0]            r_beat, r_beat_d;
  logic [AXI_ADDR_W-1:0] r_ld_addr;
  logic                  r_load, r_ld_err, rvalid_d, rlast_d;
  logic [DATA_W-1:0]     rdata_d;
  logic [1:0]            rresp_d;
  logic [ID_W-1:0]       rid_d;

  assign s_arready = gate && (r_state == R_IDLE);

  always_comb begin
    r_state_d = r_state;
    ar_cmd_d  = ar_cmd;
    r_beat_d  = r_beat;
    r_ld_addr = ar_cmd.addr;
    r_load    = 1'b0;
    rdata_d   = s_rdata;
    rresp_d   = s_rresp;
    rlast_d   = s_rlast;
    rid_d     = s_rid;
    case (r_state)
      R_IDLE: if (s_arvalid && s_arready) begin
        ar_cmd_d  = '{addr: AXI_ADDR_W'(s_araddr), len: s_arlen, size: s_arsize, burst: s_arburst};
        r_ld_addr = AXI_ADDR_W'(s_araddr);
        r_beat_d  = 8'd0;
        rid_d     = s_arid;
        r_load    = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (s_rvalid && s_rready) begin
        if (s_rlast) begin
          r_state_d = R_IDLE;
        end else begin
          r_ld_addr     = next_addr(ar_cmd.addr, ar_cmd.size, ar_cmd.len, ar_cmd.burst);
          ar_cmd_d.addr = r_ld_addr;
          r_beat_d      = r_beat + 8'd1;
          r_load        = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    r_ld_err = r_ld_addr[ADDR_W-1:2] >= IDX_W'(DEPTH);
    rvalid_d = (r_state_d == R_DATA);
    if (r_load) begin
      rdata_d = r_ld_err ? '0 : mem[r_ld_addr[MEM_AW+1:2]];
      rresp_d = r_ld_err ? RESP_SLVERR : RESP_OKAY;
      rlast_d = (r_beat_d == ar_cmd_d.len);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= R_IDLE;
      ar_cmd   <= '0;
      r_beat   <= 8'd0;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
      s_rlast  <= 1'b0;
      s_rid    <= '0;
    end else begin
      r_state  <= r_state_d;
      ar_cmd   <= ar_cmd_d;
      r_beat   <= r_beat_d;
      s_rvalid <= rvalid_d;
      s_rdata  <= rdata_d;
      s_rresp  <= rresp_d;
      s_rlast  <= rlast_d;
      s_rid    <= rid_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: expected B/R results are queued at issue and popped on output.
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  localparam int unsigned DEPTH = 1024;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        rdy_mode = 1'b0;
  logic [3:0]  rdy_thresh = 4'd0;
  logic [0:0]  s_awid = '0, s_arid = '0, s_bid, s_rid;
  logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0, s_rdata;
  logic [7:0]  s_awlen = '0, s_arlen = '0;
  logic [2:0]  s_awsize = 3'd2, s_arsize = 3'd2;
  logic [1:0]  s_awburst = 2'b01, s_arburst = 2'b01, s_bresp, s_rresp;
  logic [3:0]  s_wstrb = 4'hF;
  logic        s_awvalid = 1'b0, s_awready, s_wlast = 1'b0, s_wvalid = 1'b0, s_wready;
  logic        s_bvalid, s_bready = 1'b0, s_arvalid = 1'b0, s_arready;
  logic        s_rlast, s_rvalid, s_rready = 1'b0;

  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic id;} rbeat_t;
  typedef struct packed {logic [1:0] resp; logic id;} bexp_t;

  rbeat_t      rexp [$];
  bexp_t       bexp [$];
  logic [31:0] model [int];
  int          n_checks = 0;
  int          n_pass = 0;

  axi_mem_responder dut (
    .aclk(aclk), .aresetn(aresetn), .rdy_mode(rdy_mode), .rdy_thresh(rdy_thresh),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

  function automatic logic [31:0] tb_next(input logic [31:0] a, input int len, input logic [1:0] burst);
    logic [31:0] bytes, base;
    bytes = 32'((len + 1) * 4);
    case (burst)
      2'b00:   return a;
      2'b10: begin
        base = a - (a % bytes);
        return base + ((a - base + 32'd4) % bytes);
      end
      default: return a + 32'd4;
    endcase
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] strb, input logic id,
                          input logic [31:0] d0, input logic [31:0] step);
    logic [31:0] a, w, bd;
    int          idx, n;
    bit          err;
    bexp_t       e;
    a = addr; err = 0;
    for (int i = 0; i <= len; i++) begin
      idx = int'(a >> 2);
      bd  = d0 + step * 32'(i);
      if (idx >= int'(DEPTH)) err = 1;
      else begin
        w = model.exists(idx) ? model[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = bd[8*b +: 8];
        model[idx] = w;
      end
      a = tb_next(a, len, burst);
    end
    e.resp = err ? RESP_SLVERR : RESP_OKAY;
    e.id   = id;
    bexp.push_back(e);
    s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awsize = 3'd2; s_awburst = burst;
    s_awvalid = 1'b1;
    n = 0;
    while (!s_awready && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) begin n_checks++; $display("FAIL aw_timeout addr=%h", addr); end
    @(negedge aclk);
    s_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_wdata = d0 + step * 32'(i); s_wstrb = strb; s_wlast = (i == len); s_wvalid = 1'b1;
      n = 0;
      while (!s_wready && n < 200) begin @(negedge aclk); n++; end
      if (n >= 200) begin n_checks++; $display("FAIL w_timeout addr=%h beat=%0d", addr, i); end
      @(negedge aclk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    s_bready = 1'b1;
    n = 0;
    while (!s_bvalid && n < 200) begin @(negedge aclk); n++; end
    e = bexp.pop_front();
    n_checks++;
    if (n >= 200) $display("FAIL b_timeout addr=%h", addr);
    else if ({s_bresp, s_bid} !== {e.resp, e.id})
      $display("FAIL bresp addr=%h got resp=%b id=%b exp resp=%b id=%b", addr, s_bresp, s_bid, e.resp, e.id);
    else n_pass++;
    @(negedge aclk);
    s_bready = 1'b0;
  endtask

  // strict: mode-0 timing checks (RVALID one cycle after AR, no idle cycles between beats)
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic id, input bit rnd, input bit strict);
    logic [31:0] a, prev_data;
    logic [1:0]  prev_resp;
    int          idx, n, got, idle;
    bit          prev_stall;
    rbeat_t      e;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      idx = int'(a >> 2);
      e.data = (idx >= int'(DEPTH)) ? 32'h0 : model[idx];
      e.resp = (idx >= int'(DEPTH)) ? RESP_SLVERR : RESP_OKAY;
      e.last = (i == len);
      e.id   = id;
      rexp.push_back(e);
      a = tb_next(a, len, burst);
    end
    s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arsize = 3'd2; s_arburst = burst;
    s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) begin n_checks++; $display("FAIL ar_timeout addr=%h", addr); end
    @(negedge aclk);
    s_arvalid = 1'b0;
    if (strict) begin
      n_checks++;
      if (s_rvalid !== 1'b1) $display("FAIL r_latency addr=%h rvalid=%b exp 1", addr, s_rvalid);
      else n_pass++;
    end
    got = 0; n = 0; idle = 0; prev_stall = 0; prev_data = '0; prev_resp = '0;
    while (got <= len && n < 2000) begin
      s_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        n_checks++;
        if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, prev_data, prev_resp})
          $display("FAIL r_stable addr=%h got v=%b d=%h r=%b exp v=1 d=%h r=%b",
                   addr, s_rvalid, s_rdata, s_rresp, prev_data, prev_resp);
        else n_pass++;
      end
      if (s_rvalid) begin
        if (s_rready) begin
          e = rexp.pop_front();
          n_checks++;
          if ({s_rdata, s_rresp, s_rlast, s_rid} !== e)
            $display("FAIL rbeat addr=%h beat=%0d got d=%h r=%b l=%b id=%b exp d=%h r=%b l=%b id=%b",
                     addr, got, s_rdata, s_rresp, s_rlast, s_rid, e.data, e.resp, e.last, e.id);
          else n_pass++;
          got++;
        end
        prev_stall = !s_rready; prev_data = s_rdata; prev_resp = s_rresp;
      end else begin
        prev_stall = 0;
        idle++;
      end
      @(negedge aclk);
      n++;
    end
    s_rready = 1'b0;
    if (got <= len) begin
      n_checks++;
      $display("FAIL r_timeout addr=%h beats=%0d exp %0d", addr, got, len + 1);
      rexp.delete();
    end
    if (strict) begin
      n_checks++;
      if (idle !== 0) $display("FAIL r_idle_cycles addr=%h got %0d exp 0", addr, idle);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b000)
      $display("FAIL reset_ready got %b exp 000", {s_awready, s_wready, s_arready});
    else n_pass++;
    n_checks++;
    if ({s_bvalid, s_rvalid, s_rlast} !== 3'b000)
      $display("FAIL reset_valid got %b exp 000", {s_bvalid, s_rvalid, s_rlast});
    else n_pass++;
    n_checks++;
    if ({s_bresp, s_rresp, s_rdata, s_rid, s_bid} !== 38'h0)
      $display("FAIL reset_payload got %h exp 0", {s_bresp, s_rresp, s_rdata, s_rid, s_bid});
    else n_pass++;
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_single;
    do_write(32'h10, 0, 2'b01, 4'hF, 1'b0, 32'hDEADBEEF, 32'h0);
    do_read(32'h10, 0, 2'b01, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_incr_burst;
    do_write(32'h100, 3, 2'b01, 4'hF, 1'b1, 32'd1, 32'd1);
    do_read(32'h100, 3, 2'b01, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_wrap_fixed;
    do_write(32'h308, 3, 2'b10, 4'hF, 1'b0, 32'd5, 32'd1);
    do_read(32'h300, 3, 2'b01, 1'b0, 1'b0, 1'b1);
    do_read(32'h308, 3, 2'b10, 1'b1, 1'b0, 1'b1);
    do_write(32'h400, 1, 2'b00, 4'hF, 1'b1, 32'hA0, 32'h10);
    do_read(32'h400, 1, 2'b00, 1'b0, 1'b0, 1'b1);
    do_write(32'h500, 1, 2'b11, 4'hF, 1'b0, 32'h77, 32'h1);
    do_read(32'h500, 1, 2'b01, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_strobe;
    do_write(32'h20, 0, 2'b01, 4'hF, 1'b0, 32'h11223344, 32'h0);
    do_write(32'h20, 0, 2'b01, 4'b0101, 1'b0, 32'hAABBCCDD, 32'h0);
    do_read(32'h20, 0, 2'b01, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (model[32'h20 >> 2] !== 32'h11BB33DD) $display("FAIL strobe_model got %h exp 11BB33DD", model[8]);
    else n_pass++;
  endtask

  task automatic test_out_of_range;
    do_write(32'(DEPTH * 4 - 4), 1, 2'b01, 4'hF, 1'b1, 32'hC0, 32'h1);
    do_read(32'(DEPTH * 4 - 4), 1, 2'b01, 1'b1, 1'b0, 1'b1);
    do_write(32'(DEPTH * 4 - 4), 0, 2'b01, 4'hF, 1'b0, 32'h5A5A5A5A, 32'h0);
    do_write(32'(DEPTH * 4), 0, 2'b01, 4'hF, 1'b0, 32'h12345678, 32'h0);
    do_read(32'(DEPTH * 4), 0, 2'b01, 1'b0, 1'b0, 1'b1);
    do_read(32'(DEPTH * 4 - 4), 0, 2'b01, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random_ready;
    for (int k = 0; k < 15; k++) do_write(32'h600 + 32'(8 * k), 1, 2'b01, 4'hF, 1'b0, $urandom, 32'h01010101);
    @(negedge aclk);
    rdy_mode = 1'b1; rdy_thresh = 4'd8;
    @(negedge aclk);
    fork
      for (int k = 0; k < 15; k++)
        do_write(32'h800 + 32'(8 * k), 1, 2'b01, 4'hF, 1'(k), $urandom, 32'h01010101);
      for (int k = 0; k < 15; k++)
        do_read(32'h600 + 32'(8 * k), 1, 2'b01, 1'(k), 1'b1, 1'b0);
    join
    for (int k = 0; k < 15; k++) do_read(32'h800 + 32'(8 * k), 1, 2'b01, 1'(k), 1'b1, 1'b0);
    rdy_mode = 1'b0; rdy_thresh = 4'd0;
    @(negedge aclk);
  endtask

  task automatic test_reset_mid_read;
    int n;
    do_write(32'h200, 7, 2'b01, 4'hF, 1'b0, 32'h100, 32'h1);
    s_arid = 1'b0; s_araddr = 32'h200; s_arlen = 8'd7; s_arsize = 3'd2; s_arburst = 2'b01;
    s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (!s_arready && n < 200) begin @(negedge aclk); n++; end
    @(negedge aclk);
    s_arvalid = 1'b0;
    repeat (2) @(negedge aclk);
    n_checks++;
    if ({s_rvalid, s_rdata} !== {1'b1, 32'h102}) $display("FAIL mid_beat2 got v=%b d=%h exp v=1 d=00000102", s_rvalid, s_rdata);
    else n_pass++;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (s_rvalid !== 1'b0) $display("FAIL mid_reset_rvalid got %b exp 0", s_rvalid);
    else n_pass++;
    s_rready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++;
    if ({s_arready, s_rvalid} !== 2'b10) $display("FAIL post_reset got arready=%b rvalid=%b exp 1 0", s_arready, s_rvalid);
    else n_pass++;
    do_read(32'h10, 0, 2'b01, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_incr_burst();
    test_wrap_fixed();
    test_strobe();
    test_out_of_range();
    test_random_ready();
    test_reset_mid_read();
    repeat (2) @(negedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
